// File: rtl/vliw_pkg.sv
// Shared VLIW issue constants: bundle slot map, register file size and
// functional-unit latencies (issue to write-back, in cycles).
package vliw_pkg;

    localparam int unsigned NREG  = 32;
    localparam int unsigned NSLOT = 6;
    localparam int unsigned REG_W = 5;
    localparam int unsigned TMR_W = 5;

    localparam int unsigned LAT_ADD = 4;
    localparam int unsigned LAT_MUL = 13;
    localparam int unsigned LAT_FPA = 4;
    localparam int unsigned LAT_FPM = 25;
    localparam int unsigned LAT_LU  = 1;
    localparam int unsigned LAT_MEM = 2;

    typedef enum int unsigned {
        SLOT_ADD = 0,
        SLOT_MUL = 1,
        SLOT_FPA = 2,
        SLOT_FPM = 3,
        SLOT_LU  = 4,
        SLOT_MEM = 5
    } slot_e;

    function automatic logic [TMR_W-1:0] max_lat(input logic [TMR_W-1:0] a,
                                                 input logic [TMR_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/reg_timer.sv
// Per-register write-back countdown; busy while the count is nonzero.
// Clear beats load, load beats the running decrement.
module reg_timer
    import vliw_pkg::*;
(
    input  logic             clk,
    input  logic             clear,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    output logic             busy
);

    logic [TMR_W-1:0] count;

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - TMR_W'(1);
        end
    end

    assign busy = (count != '0);

endmodule

// File: rtl/issue_scoreboard.sv
// In-order VLIW issue scoreboard: stalls a bundle while any source or
// destination register has a pending write, and tracks write-back timers.
module issue_scoreboard #(
    parameter int unsigned NREG    = vliw_pkg::NREG,
    parameter int unsigned NSLOT   = vliw_pkg::NSLOT,
    parameter int unsigned LAT_ADD = vliw_pkg::LAT_ADD,
    parameter int unsigned LAT_MUL = vliw_pkg::LAT_MUL,
    parameter int unsigned LAT_FPA = vliw_pkg::LAT_FPA,
    parameter int unsigned LAT_FPM = vliw_pkg::LAT_FPM,
    parameter int unsigned LAT_LU  = vliw_pkg::LAT_LU,
    parameter int unsigned LAT_MEM = vliw_pkg::LAT_MEM
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               bnd_valid,
    output logic               bnd_ready,
    input  logic [NSLOT-1:0]   slot_valid,
    input  logic [5*NSLOT-1:0] src_a,
    input  logic [5*NSLOT-1:0] src_b,
    input  logic [5*NSLOT-1:0] dst,
    input  logic [4:0]         mul_dst2,
    input  logic               flush,
    output logic               issue,
    output logic [NREG-1:0]    busy_vec,
    output logic [15:0]        stall_cnt,
    output logic               err
);

    localparam int unsigned RW = vliw_pkg::REG_W;
    localparam int unsigned TW = vliw_pkg::TMR_W;

    logic [NSLOT-1:0] hazard;
    logic             accept;
    logic             dup;
    logic             tmr_clear;
    logic [NREG-1:0]  load_en;
    logic [TW-1:0]    load_val [NREG];
    logic             unused_r0;

    function automatic logic [RW-1:0] fld(input logic [5*NSLOT-1:0] v,
                                          input int unsigned n);
        return v[RW*n +: RW];
    endfunction

    function automatic logic [TW-1:0] slot_lat(input int unsigned n);
        case (n)
            vliw_pkg::SLOT_ADD: slot_lat = TW'(LAT_ADD);
            vliw_pkg::SLOT_MUL: slot_lat = TW'(LAT_MUL);
            vliw_pkg::SLOT_FPA: slot_lat = TW'(LAT_FPA);
            vliw_pkg::SLOT_FPM: slot_lat = TW'(LAT_FPM);
            vliw_pkg::SLOT_LU:  slot_lat = TW'(LAT_LU);
            vliw_pkg::SLOT_MEM: slot_lat = TW'(LAT_MEM);
            default:            slot_lat = '0;
        endcase
    endfunction

    // busy_vec[0] is hard zero, so R0 operands never raise a hazard.
    always_comb begin
        hazard = '0;
        for (int unsigned n = 0; n < NSLOT; n++) begin
            if (slot_valid[n] && (busy_vec[fld(src_a, n)] ||
                                  busy_vec[fld(src_b, n)] ||
                                  busy_vec[fld(dst, n)])) begin
                hazard[n] = 1'b1;
            end
        end
        if (slot_valid[vliw_pkg::SLOT_MUL] && busy_vec[mul_dst2]) begin
            hazard[vliw_pkg::SLOT_MUL] = 1'b1;
        end
    end

    assign bnd_ready = rst | ~(|hazard);
    assign accept    = bnd_valid & bnd_ready & ~rst;
    assign tmr_clear = rst | flush;

    // Per-register load value is the longest latency of all writers in the
    // bundle; only the slot dst fields count towards the duplicate error.
    always_comb begin
        dup     = 1'b0;
        load_en = '0;
        for (int unsigned r = 0; r < NREG; r++) begin
            load_val[r] = '0;
        end
        for (int unsigned n = 0; n < NSLOT; n++) begin
            if (slot_valid[n] && fld(dst, n) != '0) begin
                if (load_en[fld(dst, n)]) begin
                    dup = 1'b1;
                end
                load_en[fld(dst, n)]  = 1'b1;
                load_val[fld(dst, n)] = vliw_pkg::max_lat(load_val[fld(dst, n)],
                                                          slot_lat(n));
            end
        end
        if (slot_valid[vliw_pkg::SLOT_MUL] && mul_dst2 != '0) begin
            load_en[mul_dst2]  = 1'b1;
            load_val[mul_dst2] = vliw_pkg::max_lat(load_val[mul_dst2], TW'(LAT_MUL));
        end
    end

    assign busy_vec[0] = 1'b0;
    assign unused_r0   = load_en[0] | (|load_val[0]);

    for (genvar r = 1; r < NREG; r++) begin : g_tmr
        reg_timer u_tmr (
            .clk      (clk),
            .clear    (tmr_clear),
            .load     (accept & load_en[r]),
            .load_val (load_val[r]),
            .busy     (busy_vec[r])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issue     <= 1'b0;
            err       <= 1'b0;
            stall_cnt <= '0;
        end else begin
            issue <= accept;
            err   <= accept & dup;
            if (bnd_valid && !bnd_ready && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed and randomized bench for issue_scoreboard against a per-register
// integer timer model.
module tb_issue_scoreboard;

    localparam int NS = 6;
    localparam int LAT [6] = '{4, 13, 4, 25, 1, 2};

    logic        clk = 1'b0;
    logic        rst, bnd_valid, flush;
    logic        bnd_ready, issue, err;
    logic [5:0]  slot_valid;
    logic [29:0] src_a, src_b, dst;
    logic [4:0]  mul_dst2;
    logic [31:0] busy_vec;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    int tm [32];
    int m_stall;
    bit m_issue, m_err;

    always #5 clk = ~clk;

    issue_scoreboard dut (
        .clk        (clk),
        .rst        (rst),
        .bnd_valid  (bnd_valid),
        .bnd_ready  (bnd_ready),
        .slot_valid (slot_valid),
        .src_a      (src_a),
        .src_b      (src_b),
        .dst        (dst),
        .mul_dst2   (mul_dst2),
        .flush      (flush),
        .issue      (issue),
        .busy_vec   (busy_vec),
        .stall_cnt  (stall_cnt),
        .err        (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] f(input logic [29:0] v, input int n);
        return v[5*n +: 5];
    endfunction

    function automatic bit m_busy(input logic [4:0] r);
        return (r != 0) && (tm[r] > 0);
    endfunction

    function automatic bit m_ready();
        if (rst) return 1'b1;
        for (int n = 0; n < NS; n++) begin
            if (slot_valid[n]) begin
                if (m_busy(f(src_a, n)) || m_busy(f(src_b, n)) || m_busy(f(dst, n)))
                    return 1'b0;
                if (n == 1 && m_busy(mul_dst2)) return 1'b0;
            end
        end
        return 1'b1;
    endfunction

    function automatic logic [31:0] m_busyvec();
        logic [31:0] v = '0;
        for (int r = 1; r < 32; r++) v[r] = (tm[r] > 0);
        return v;
    endfunction

    // Check all outputs against the model, clock once, advance the model.
    task automatic cyc();
        bit rdy, acc, dup;
        int ld [32];
        #1;
        rdy = m_ready();
        chk("bnd_ready", 32'(bnd_ready), 32'(rdy));
        chk("issue", 32'(issue), 32'(m_issue));
        chk("err", 32'(err), 32'(m_err));
        chk("busy_vec", busy_vec, m_busyvec());
        chk("stall_cnt", 32'(stall_cnt), m_stall);
        @(posedge clk);
        acc = bnd_valid && rdy && !rst;
        if (rst) begin
            for (int r = 0; r < 32; r++) tm[r] = 0;
            m_stall = 0;
            m_issue = 0;
            m_err   = 0;
        end else begin
            dup = 0;
            for (int r = 0; r < 32; r++) ld[r] = 0;
            if (acc) begin
                for (int n = 0; n < NS; n++) begin
                    if (slot_valid[n] && f(dst, n) != 0) begin
                        if (ld[f(dst, n)] != 0) dup = 1;
                        if (LAT[n] > ld[f(dst, n)]) ld[f(dst, n)] = LAT[n];
                    end
                end
                if (slot_valid[1] && mul_dst2 != 0 && LAT[1] > ld[mul_dst2])
                    ld[mul_dst2] = LAT[1];
            end
            m_issue = acc;
            m_err   = acc && dup;
            if (bnd_valid && !rdy && m_stall < 65535) m_stall++;
            for (int r = 1; r < 32; r++) begin
                if (flush) tm[r] = 0;
                else if (ld[r] != 0) tm[r] = ld[r];
                else if (tm[r] > 0) tm[r]--;
            end
        end
        #1;
    endtask

    task automatic idle();
        bnd_valid  = 0;
        flush      = 0;
        slot_valid = '0;
        src_a      = '0;
        src_b      = '0;
        dst        = '0;
        mul_dst2   = '0;
    endtask

    task automatic put(input int n, input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
        slot_valid[n]  = 1'b1;
        src_a[5*n +: 5] = a;
        src_b[5*n +: 5] = b;
        dst[5*n +: 5]   = d;
    endtask

    task automatic do_rst();
        idle();
        rst = 1;
        cyc();
        rst = 0;
    endtask

    initial begin
        idle();
        rst = 1;
        @(posedge clk);
        #1;
        for (int r = 0; r < 32; r++) tm[r] = 0;
        m_stall = 0;
        m_issue = 0;
        m_err   = 0;
        cyc();
        chk("rst_busy", busy_vec, 32'h0);
        chk("rst_stall", 32'(stall_cnt), 32'h0);
        rst = 0;

        // ADD dst=5: busy for cycles 1-4
        put(0, 0, 0, 5); bnd_valid = 1;
        cyc();
        chk("add_issue", 32'(issue), 32'h1);
        chk("add_busy_c1", 32'(busy_vec[5]), 32'h1);
        idle();
        for (int i = 2; i <= 4; i++) begin
            cyc();
            chk("add_busy_mid", 32'(busy_vec[5]), 32'h1);
            chk("add_issue_once", 32'(issue), 32'h0);
        end
        cyc();
        chk("add_free_c5", 32'(busy_vec[5]), 32'h0);

        // FPM dst=7 then LU reads r7: 25 stall cycles
        do_rst();
        put(3, 0, 0, 7); bnd_valid = 1;
        cyc();
        idle();
        put(4, 7, 0, 0); bnd_valid = 1;
        repeat (25) cyc();
        chk("fpm_stall25", 32'(stall_cnt), 32'd25);
        chk("fpm_ready", 32'(bnd_ready), 32'h1);
        cyc();
        chk("fpm_dep_issue", 32'(issue), 32'h1);

        // MUL with two destinations, WAW on the low word
        do_rst();
        put(1, 0, 0, 8); mul_dst2 = 9; bnd_valid = 1;
        cyc();
        idle();
        put(0, 0, 0, 9); bnd_valid = 1;
        for (int i = 0; i < 13; i++) begin
            chk("mul_pair_busy", 32'(busy_vec[9:8]), 32'h3);
            cyc();
        end
        chk("mul_pair_free", 32'(busy_vec[9:8]), 32'h0);
        chk("mul_stall13", 32'(stall_cnt), 32'd13);

        // Duplicate destination ADD/LU -> err once, max latency 4
        do_rst();
        put(0, 0, 0, 3); put(4, 0, 0, 3); bnd_valid = 1;
        cyc();
        chk("dup_err", 32'(err), 32'h1);
        idle();
        cyc();
        chk("dup_err_once", 32'(err), 32'h0);
        cyc();
        cyc();
        chk("dup_busy_c4", 32'(busy_vec[3]), 32'h1);
        cyc();
        chk("dup_free_c5", 32'(busy_vec[3]), 32'h0);

        // Flush of a pending FPM write
        do_rst();
        put(3, 0, 0, 10); bnd_valid = 1;
        cyc();
        idle();
        cyc();
        cyc();
        flush = 1;
        cyc();
        flush = 0;
        chk("flush_busy", busy_vec, 32'h0);
        put(4, 10, 0, 0); bnd_valid = 1;
        #1;
        chk("flush_dep_ready", 32'(bnd_ready), 32'h1);
        cyc();
        chk("flush_dep_issue", 32'(issue), 32'h1);

        // Flush together with acceptance: issues, loads discarded
        do_rst();
        put(0, 0, 0, 6); bnd_valid = 1; flush = 1;
        cyc();
        chk("flush_acc_issue", 32'(issue), 32'h1);
        chk("flush_acc_busy", busy_vec, 32'h0);

        // Reset mid-operation with timers loaded and stall_cnt=12
        do_rst();
        put(3, 0, 0, 11); put(0, 0, 0, 12); bnd_valid = 1;
        cyc();
        idle();
        put(5, 11, 0, 0); bnd_valid = 1;
        repeat (12) cyc();
        chk("pre_rst_stall", 32'(stall_cnt), 32'd12);
        rst = 1;
        #1;
        chk("rst_ready_during", 32'(bnd_ready), 32'h1);
        cyc();
        rst = 0;
        chk("rst_mid_busy", busy_vec, 32'h0);
        chk("rst_mid_stall", 32'(stall_cnt), 32'h0);
        chk("rst_mid_issue", 32'(issue), 32'h0);
        #1;
        chk("rst_mid_ready", 32'(bnd_ready), 32'h1);
        cyc();

        // Randomized bundles, flushes and occasional resets
        for (int i = 0; i < 800; i++) begin
            idle();
            rst       = ($urandom_range(99) == 0);
            flush     = ($urandom_range(29) == 0);
            bnd_valid = ($urandom_range(3) != 0);
            for (int n = 0; n < NS; n++) begin
                if ($urandom_range(2) == 0)
                    put(n, 5'($urandom_range(15)), 5'($urandom_range(15)), 5'($urandom_range(15)));
            end
            if (slot_valid[1] && $urandom_range(1) == 1) mul_dst2 = 5'($urandom_range(1, 15));
            for (int n = 0; n < NS; n++) begin
                if (slot_valid[n] && f(dst, n) == mul_dst2) mul_dst2 = '0;
            end
            cyc();
        end
        rst = 0;
        idle();
        repeat (30) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/issue_scoreboard.md
ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

Interface
REQ-001 Parameter NREG, 32, architectural register count; R0 is never tracked.
REQ-002 Parameter NSLOT, 6, bundle slots: 0 ADD, 1 MUL, 2 FPA, 3 FPM, 4 LU, 5 MEM.
REQ-003 Parameters LAT_ADD 4, LAT_MUL 13, LAT_FPA 4, LAT_FPM 25, LAT_LU 1, LAT_MEM 2; cycles from issue to write-back.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 bnd_valid  in  1  decoded bundle presented.
REQ-007 bnd_ready  out  1  combinational; bundle hazard-free, may issue this cycle.
REQ-008 slot_valid  in  6  per-slot instruction present.
REQ-009 src_a  in  30  slot n first source at [5n+4:5n].
REQ-010 src_b  in  30  slot n second source at [5n+4:5n].
REQ-011 dst  in  30  slot n destination at [5n+4:5n]; 0 = no write.
REQ-012 mul_dst2  in  5  MUL low-word destination; 0 = no write.
REQ-013 flush  in  1  clears all pending writes.
REQ-014 issue  out  1  registered pulse; bundle accepted previous cycle.
REQ-015 busy_vec  out  32  bit r set while register r has a pending write.
REQ-016 stall_cnt  out  16  saturating count of stall cycles.
REQ-017 err  out  1  registered pulse; accepted bundle had a duplicate destination.

Function
REQ-018 Each register r in 1..31 SHALL own a 5-bit countdown timer; busy_vec[r] = (timer != 0); busy_vec[0] SHALL be 0.
REQ-019 A slot SHALL hazard when slot_valid is set and any of src_a, src_b, dst (and mul_dst2 for slot 1) names a busy register; register 0 never hazards.
REQ-020 bnd_ready SHALL be 1 iff no slot hazards, independent of bnd_valid.
REQ-021 Acceptance SHALL occur on a cycle with bnd_valid and bnd_ready both 1; issue SHALL be 1 the following cycle only.
REQ-022 On acceptance each valid slot's nonzero dst timer SHALL load that slot's latency; slot 1 mul_dst2 SHALL load LAT_MUL.
REQ-023 Timers not loaded SHALL decrement by 1 per cycle while nonzero; load SHALL override decrement in the same cycle.
REQ-024 No bypass: a register with timer 1 SHALL still be busy that cycle and free the next.
REQ-025 Duplicate nonzero destination among valid slots of an accepted bundle SHALL load the maximum of the involved latencies and pulse err the next cycle.
REQ-026 stall_cnt SHALL increment each cycle with bnd_valid=1 and bnd_ready=0, holding at 16'hFFFF.
REQ-027 flush SHALL zero all timers next edge; a same-cycle acceptance SHALL still issue but its timer loads are discarded.
REQ-028 Invalid slots SHALL contribute neither hazards nor timer loads.

Reset
REQ-029 On rst all timers, busy_vec, stall_cnt, issue and err SHALL be 0 after the next rising edge.
REQ-030 rst SHALL override flush and acceptance; a bundle presented during rst SHALL NOT issue.
REQ-031 bnd_ready SHALL be 1 during and after rst until a load occurs.

Structure
REQ-032 Slot indices, NSLOT, NREG and the LAT_* constants SHALL live in shared package vliw_pkg.
REQ-033 The per-register countdown (load value, load enable, clear, busy) SHALL be sub-module reg_timer, instantiated 31 times.
REQ-034 Hazard detection and latency selection SHALL be combinational; only timers, issue, err and stall_cnt are registered.

Verification
REQ-035 Slot 0 ADD dst=5 accepted at cycle 0 -> busy_vec[5]=1 cycles 1-4, 0 at cycle 5; issue=1 at cycle 1.
REQ-036 Slot 3 FPM dst=7, then slot 4 LU src_a=7 -> bnd_ready=0 for 25 cycles, stall_cnt=25, issue on cycle 26.
REQ-037 Slot 1 MUL dst=8, mul_dst2=9, then slot 0 dst=9 -> WAW stall 13 cycles; busy_vec[8] and [9] clear together.
REQ-038 Slot 0 dst=3 and slot 4 dst=3 in one bundle -> err pulse once, timer[3]=4.
REQ-039 FPM dst=10 pending, flush at cycle 3 -> busy_vec=0 at cycle 4; dependent bundle issues immediately.
REQ-040 rst asserted mid-operation with timers loaded and stall_cnt=12 -> busy_vec=0, stall_cnt=0, bnd_ready=1 next cycle.
